// File: rtl/mlkem_pkg.sv
// mlkem_pkg: shared ML-KEM modulus constants and Barrett reduction parameters
package mlkem_pkg;
  localparam int MLKEM_Q = 3329;
  localparam int BAR_SHIFT = 26;
  function automatic int half_q(input int q);
    return (q + 1) / 2;
  endfunction
  function automatic int barrett_m(input int q);
    return (1 << BAR_SHIFT) / q;
  endfunction
endpackage

// File: rtl/modq_mul.sv
// modq_mul: a*b mod Q as registered full product followed by registered Barrett reduction
module modq_mul
  import mlkem_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int Q = MLKEM_Q
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o
);
  localparam int PW = 2 * WIDTH;
  localparam longint BM = longint'(barrett_m(Q));
  logic [PW-1:0] prod_q, qe, rr;
  logic [WIDTH-1:0] r_q;
  // quotient estimate is at most one short, so one conditional subtract suffices
  assign qe = PW'((64'(prod_q) * 64'(BM)) >> BAR_SHIFT);
  assign rr = prod_q - qe * PW'(Q);
  always_ff @(posedge clk)
    if (en_i) begin
      prod_q <= PW'(a_i) * PW'(b_i);
      r_q <= rr >= PW'(Q) ? WIDTH'(rr - PW'(Q)) : WIDTH'(rr);
    end
  assign r_o = r_q;
endmodule

// File: rtl/ntt_bfu_pipe.sv
// ntt_bfu_pipe: 4-stage multi-lane NTT/INTT butterfly over Z_Q with valid/ready backpressure
module ntt_bfu_pipe
  import mlkem_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int Q = MLKEM_Q,
  parameter int LANES = 2,
  parameter int TAG_W = 8,
  parameter int HALF_INTT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_w,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_u,
  output logic [LANES*WIDTH-1:0] out_v,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_mode,
  output logic                   busy
);
  localparam int LW = LANES * WIDTH;
  localparam logic [WIDTH:0] QX = (WIDTH + 1)'(Q);
  localparam logic [WIDTH-1:0] QH = WIDTH'(half_q(Q));
  function automatic logic [WIDTH-1:0] addm(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s >= QX ? WIDTH'(s - QX) : WIDTH'(s);
  endfunction
  function automatic logic [WIDTH-1:0] subm(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[WIDTH] ? WIDTH'(d + QX) : WIDTH'(d);
  endfunction
  // (x odd ? x+Q : x) >> 1, folded as (x >> 1) + (Q+1)/2 for odd x
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
    return (x >> 1) + (x[0] ? QH : '0);
  endfunction
  logic adv, v1_q, v2_q, v3_q, ov_q, mode1_q, mode2_q, mode3_q, out_mode_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, out_tag_q;
  logic [LW-1:0] p1_d, m1_d, p1_q, m1_q, w1_q, p2_q, p3_q, u_d, v_d, out_u_q, out_v_q;
  assign adv = !ov_q || out_ready;
  assign in_ready = adv;
  assign busy = v1_q | v2_q | v3_q | ov_q;
  assign out_valid = ov_q;
  assign out_u = out_u_q;
  assign out_v = out_v_q;
  assign out_tag = out_tag_q;
  assign out_mode = out_mode_q;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] a, b, p, r, u, v;
    assign a = in_a[k*WIDTH +: WIDTH];
    assign b = in_b[k*WIDTH +: WIDTH];
    assign p1_d[k*WIDTH +: WIDTH] = in_mode ? a : addm(a, b);
    assign m1_d[k*WIDTH +: WIDTH] = in_mode ? b : subm(a, b);
    modq_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (
      .clk (clk),
      .en_i(adv),
      .a_i (w1_q[k*WIDTH +: WIDTH]),
      .b_i (m1_q[k*WIDTH +: WIDTH]),
      .r_o (r)
    );
    assign p = p3_q[k*WIDTH +: WIDTH];
    assign u = mode3_q ? addm(p, r) : p;
    assign v = mode3_q ? subm(p, r) : r;
    assign u_d[k*WIDTH +: WIDTH] = (!mode3_q && HALF_INTT != 0) ? halve(u) : u;
    assign v_d[k*WIDTH +: WIDTH] = (!mode3_q && HALF_INTT != 0) ? halve(v) : v;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      {v1_q, v2_q, v3_q, ov_q} <= '0;
      out_u_q <= '0;
      out_v_q <= '0;
      out_tag_q <= '0;
      out_mode_q <= 1'b0;
    end else if (flush) begin
      {v1_q, v2_q, v3_q, ov_q} <= '0;
    end else if (adv) begin
      {v1_q, v2_q, v3_q, ov_q} <= {in_valid, v1_q, v2_q, v3_q};
      if (v3_q) begin
        out_u_q <= u_d;
        out_v_q <= v_d;
        out_tag_q <= tag3_q;
        out_mode_q <= mode3_q;
      end
    end
  // data stages move freely; only the valid bits decide what reaches the output
  always_ff @(posedge clk)
    if (adv) begin
      p1_q <= p1_d;
      m1_q <= m1_d;
      w1_q <= in_w;
      mode1_q <= in_mode;
      tag1_q <= in_tag;
      p2_q <= p1_q;
      mode2_q <= mode1_q;
      tag2_q <= tag1_q;
      p3_q <= p2_q;
      mode3_q <= mode2_q;
      tag3_q <= tag2_q;
    end
endmodule

// File: tb/tb_ntt_bfu_pipe.sv
// tb_ntt_bfu_pipe: directed and random checks of ntt_bfu_pipe against a plain-arithmetic butterfly model
module tb_ntt_bfu_pipe;
  localparam int W = 12;
  localparam int Q = 3329;
  localparam int L = 2;
  localparam int TW = 8;
  localparam int HALF = 1;
  localparam int LW = L * W;
  typedef struct packed {
    logic [LW-1:0] u;
    logic [LW-1:0] v;
    logic [TW-1:0] tag;
    logic          mode;
  } exp_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_mode = 0, out_ready = 1;
  logic [LW-1:0] in_a = '0, in_b = '0, in_w = '0;
  logic [TW-1:0] in_tag = '0;
  logic in_ready, out_valid, out_mode, busy;
  logic [LW-1:0] out_u, out_v;
  logic [TW-1:0] out_tag;
  int total = 0, bad = 0, ndel = 0, cyc = 0;
  bit log_en = 0, rnd_en = 0, stall_prev = 0;
  exp_t exp_q[$];
  exp_t held;
  int log_tag[$], log_cyc[$];

  ntt_bfu_pipe #(.WIDTH(W), .Q(Q), .LANES(L), .TAG_W(TW), .HALF_INTT(HALF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .out_v(out_v),
    .out_tag(out_tag), .out_mode(out_mode), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic void bfly(input int a, input int b, input int w, input bit mode, input bit half,
                               output int u, output int v);
    int t;
    if (mode) begin
      t = (w * b) % Q;
      u = (a + t) % Q;
      v = (a - t + Q) % Q;
    end else begin
      u = (a + b) % Q;
      v = (w * ((a - b + Q) % Q)) % Q;
      if (half) begin
        u = (u * ((Q + 1) / 2)) % Q;
        v = (v * ((Q + 1) / 2)) % Q;
      end
    end
  endfunction

  function automatic exp_t model(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic [LW-1:0] w,
                                 input logic mode, input logic [TW-1:0] tag);
    exp_t e;
    int u, v;
    e = '0;
    e.tag = tag;
    e.mode = mode;
    for (int k = 0; k < L; k++) begin
      bfly(int'(a[k*W +: W]), int'(b[k*W +: W]), int'(w[k*W +: W]), mode, HALF != 0, u, v);
      e.u[k*W +: W] = W'(u);
      e.v[k*W +: W] = W'(v);
    end
    return e;
  endfunction

  function automatic int rnd();
    int p;
    p = $urandom_range(0, 7);
    return p == 0 ? 0 : p == 1 ? Q - 1 : int'($urandom_range(0, Q - 1));
  endfunction

  function automatic logic [LW-1:0] rvec();
    logic [LW-1:0] r;
    for (int k = 0; k < L; k++) r[k*W +: W] = W'(rnd());
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      chk("ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (stall_prev) chk("hold", {out_valid, out_u, out_v, out_tag, out_mode}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious: out_valid with tag %0h, required no beat", out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_u, out_v, out_tag, out_mode}, e);
          ndel++;
          if (log_en) begin
            log_tag.push_back(int'(out_tag));
            log_cyc.push_back(cyc);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_u, out_v, out_tag, out_mode};
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_w, in_mode, in_tag));
    end
  end

  always @(posedge clk)
    if (rnd_en) begin
      #1;
      out_ready = $urandom_range(0, 3) != 0;
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic [LW-1:0] w,
                      input logic m, input logic [TW-1:0] t);
    bit acc;
    int n;
    in_a = a; in_b = b; in_w = w; in_mode = m; in_tag = t; in_valid = 1; n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready 0 for %0d cycles, required 1", n);
    end
    in_valid = 0;
  endtask

  task automatic one(input int a, input int b, input int w, input bit m, input int eu, input int ev);
    int n;
    in_a = {L{W'(a)}}; in_b = {L{W'(b)}}; in_w = {L{W'(w)}}; in_mode = m; in_tag = 8'hA5; in_valid = 1;
    tick();
    in_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency", 64'(n), 64'd4);
    chk("lit_u", 64'(out_u), 64'({L{W'(eu)}}));
    chk("lit_v", 64'(out_v), 64'({L{W'(ev)}}));
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int u, v, n0, cnt;
    bfly(1, 1, 17, 1, 1, u, v);
    chk("model_ntt_u", 64'(u), 64'd18);
    chk("model_ntt_v", 64'(v), 64'd3313);
    bfly(5, 3, 17, 0, 0, u, v);
    chk("model_intt_full_u", 64'(u), 64'd8);
    chk("model_intt_full_v", 64'(v), 64'd34);
    bfly(5, 3, 17, 0, 1, u, v);
    chk("model_intt_half_u", 64'(u), 64'd4);
    chk("model_intt_half_v", 64'(v), 64'd17);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_outs", {out_valid, busy, out_u, out_v, out_tag, out_mode}, 64'd0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("rel_ready", 64'(in_ready), 64'd1);
    tick();
    one(1, 1, 17, 1, 18, 3313);
    one(0, 3328, 3328, 1, 1, 3328);
    one(5, 3, 17, 0, 4, 17);
    // back-to-back alternating modes
    log_tag.delete();
    log_cyc.delete();
    log_en = 1;
    for (int i = 0; i < 8; i++) send(rvec(), rvec(), rvec(), i[0], TW'(i));
    repeat (8) tick();
    log_en = 0;
    chk("b2b_count", 64'(log_tag.size()), 64'd8);
    for (int i = 0; i < log_tag.size(); i++) begin
      chk("b2b_tag", 64'(log_tag[i]), 64'(i));
      chk("b2b_cycle", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end
    // backpressure mid-stream
    n0 = ndel;
    fork
      for (int i = 0; i < 8; i++) send(rvec(), rvec(), rvec(), $urandom_range(0, 1) != 0, TW'(8'h10 + i));
      begin
        repeat (5) tick();
        out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready", 64'(in_ready), 64'd0);
          tick();
        end
        out_ready = 1;
      end
    join
    drain();
    chk("stall_count", 64'(ndel - n0), 64'd8);
    // flush with three beats in flight plus one offered on the flush cycle
    n0 = ndel;
    for (int i = 0; i < 3; i++) send(rvec(), rvec(), rvec(), 1'b1, TW'(8'h20 + i));
    flush = 1;
    in_valid = 1;
    tick();
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("flush_busy", {busy, out_valid}, 64'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(out_valid);
    end
    chk("flush_quiet", 64'(cnt), 64'd0);
    chk("flush_ndel", 64'(ndel - n0), 64'd0);
    tick();
    one(7, 9, 100, 1, 907, 2436);
    // reset with four beats in flight
    n0 = ndel;
    for (int i = 0; i < 4; i++) send(rvec(), rvec(), rvec(), 1'b0, TW'(8'h30 + i));
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_outs", {out_valid, busy, out_u, out_v, out_tag, out_mode}, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(out_valid);
    end
    chk("mid_rst_quiet", 64'(cnt), 64'd0);
    tick();
    // random traffic with random backpressure
    rnd_en = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      send(rvec(), rvec(), rvec(), $urandom_range(0, 1) != 0, TW'($urandom_range(0, 255)));
    end
    rnd_en = 0;
    repeat (2) tick();
    out_ready = 1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
